// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and rr_arbiter8.
//   req         : request lines, one per requester (driven by master)
//   grant       : registered one-hot grant (driven by slave)
//   grant_idx   : binary index of the granted requester, 0 when idle
//   grant_valid : a grant is currently outstanding
//   lock        : (RR_ARBITER8_LOCK_EN only) extends the current grant
// Modports: master = requester side, slave = arbiter side.
interface rr_arbiter8_if;
  logic [7:0] req;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       grant_valid;
`ifdef RR_ARBITER8_LOCK_EN
  logic       lock;

  modport master (output req, output lock, input grant, input grant_idx, input grant_valid);
  modport slave  (input req, input lock, output grant, output grant_idx, output grant_valid);
`else
  modport master (output req, input grant, input grant_idx, input grant_valid);
  modport slave  (input req, output grant, output grant_idx, output grant_valid);
`endif
endinterface

// File: rtl/rr_arbiter8.sv
// Round-robin arbiter for 8 requesters with a per-grant burst limit.
// Ports:
//   clk  : clock, all logic on the rising edge
//   rst  : synchronous active-high reset
//   bus  : rr_arbiter8_if.slave (req in; grant, grant_idx, grant_valid out;
//          lock in when RR_ARBITER8_LOCK_EN is defined)
// Parameter MAX_HOLD: max consecutive cycles a grant is held, 0 = unlimited.
// Optional macro RR_ARBITER8_LOCK_EN adds the lock input, which freezes the
// hold counter and suppresses the limit release while a grant is active.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 4
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter8_if.slave bus
);

  localparam int unsigned HOLD_W   = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam int unsigned HOLD_LIM = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state_q, state_nxt;
  logic [7:0]          grant_q, grant_nxt;
  logic [2:0]          idx_q, idx_nxt;
  logic                valid_q, valid_nxt;
  logic [2:0]          ptr_q, ptr_nxt;
  logic [HOLD_W-1:0]   hold_q, hold_nxt;
  logic                lock_on;
  logic [2:0]          scan_start;
  logic [3:0]          pick;
  logic                limit_hit;

  // First set request scanning upward from start, wrapping 7->0; {found, idx}.
  function automatic logic [3:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic       found;
    logic [2:0] idx;
    logic [2:0] cand;
    found = 1'b0;
    idx   = 3'd0;
    for (int k = 0; k < 8; k++) begin
      cand = start + 3'(k);
      if (!found && r[cand]) begin
        found = 1'b1;
        idx   = cand;
      end
    end
    return {found, idx};
  endfunction

`ifdef RR_ARBITER8_LOCK_EN
  assign lock_on = bus.lock;
`else
  assign lock_on = 1'b0;
`endif

  // On release the scan starts just past the current owner.
  assign scan_start = (state_q == GRANT) ? (idx_q + 3'd1) : ptr_q;
  assign pick       = rr_pick(bus.req, scan_start);
  assign limit_hit  = (MAX_HOLD != 0) && (32'(hold_q) >= HOLD_LIM);

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= 8'h00;
      idx_q   <= 3'd0;
      valid_q <= 1'b0;
      ptr_q   <= 3'd0;
      hold_q  <= '0;
    end else begin
      state_q <= state_nxt;
      grant_q <= grant_nxt;
      idx_q   <= idx_nxt;
      valid_q <= valid_nxt;
      ptr_q   <= ptr_nxt;
      hold_q  <= hold_nxt;
    end
  end

  // Next-state: hold the owner, or release and re-arbitrate without a gap.
  always_comb begin
    state_nxt = state_q;
    grant_nxt = grant_q;
    idx_nxt   = idx_q;
    valid_nxt = valid_q;
    ptr_nxt   = ptr_q;
    hold_nxt  = hold_q;
    unique case (state_q)
      IDLE: begin
        if (pick[3]) begin
          state_nxt = GRANT;
          grant_nxt = 8'(1) << pick[2:0];
          idx_nxt   = pick[2:0];
          valid_nxt = 1'b1;
          hold_nxt  = '0;
        end
      end
      GRANT: begin
        if (bus.req[idx_q] && (lock_on || !limit_hit)) begin
          if (!lock_on) hold_nxt = hold_q + HOLD_W'(1);
        end else begin
          ptr_nxt  = idx_q + 3'd1;
          hold_nxt = '0;
          if (pick[3]) begin
            grant_nxt = 8'(1) << pick[2:0];
            idx_nxt   = pick[2:0];
          end else begin
            state_nxt = IDLE;
            grant_nxt = 8'h00;
            idx_nxt   = 3'd0;
            valid_nxt = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.grant       = grant_q;
  assign bus.grant_idx   = idx_q;
  assign bus.grant_valid = valid_q;

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter that shares one resource between 8 requesters.
- Produces a registered one-hot grant and its 3-bit encoded index (8-to-3 encoding of the grant vector).
- Sits in front of any shared datapath unit. Downstream logic steers the mux and datapath from grant_idx.
- Grants are held per requester with an optional burst limit so no requester can starve the others.

Parameters:
- MAX_HOLD, 4, maximum consecutive cycles one grant is held. 0 = unlimited (release only on request drop).

Ports:
- clk  input  1  clock; all logic on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  8  request lines; req[i]=1 means requester i wants the resource
- grant  output  8  one-hot grant, registered; all zeros when nothing is granted
- grant_idx  output  3  binary index of the set bit in grant; 3'd0 when grant_valid=0
- grant_valid  output  1  1 when grant is non-zero
- (LOCK_EN only) lock  input  1  extends the current grant past MAX_HOLD

Behaviour:
- Clock and reset:
  - One clock, clk.
  - rst is synchronous and active-high.
  - On rst=1 at a rising edge: grant=8'h00, grant_idx=3'd0, grant_valid=0, pointer=3'd0, hold_cnt=0, state=IDLE.
  - rst overrides all other inputs, including mid-grant.
- Internal state:
  - pointer (3b): highest-priority requester for the next arbitration.
  - hold_cnt: width clog2(MAX_HOLD), minimum 1 bit.
  - FSM states: IDLE, GRANT.
- Arbitration function:
  - Scan req starting at index pointer, ascending, wrapping 7->0.
  - The first set bit wins.
  - Pure combinational. Result is registered into grant and grant_idx.
- IDLE:
  - req==0: stay in IDLE, outputs stay 0.
  - req!=0: next edge loads grant/grant_idx of the winner, grant_valid=1, hold_cnt=0, state=GRANT.
  - Latency from req sampled high to grant visible: 1 cycle.
- GRANT, current owner g:
  - Hold condition: req[g]=1 and (MAX_HOLD==0 or hold_cnt < MAX_HOLD-1). While held, hold_cnt increments each cycle and outputs are unchanged.
  - Release condition: req[g]=0, or hold_cnt==MAX_HOLD-1 with MAX_HOLD!=0.
    - A limit release means g was held exactly MAX_HOLD cycles.
  - On release: pointer <= g+1 mod 8, and re-arbitrate in the same cycle starting from g+1.
    - Any req set: new grant on the next edge with no idle gap; grant_valid stays 1; hold_cnt=0.
    - g itself wins only if it is the sole requester. In that case grant stays the same, hold_cnt restarts at 0, and grant_valid does not drop.
    - req==0: grant cleared, grant_valid=0, grant_idx=0, state=IDLE.
- Request drop latency:
  - The owner drops req[g] in cycle n.
  - grant changes at the edge ending cycle n and is visible in cycle n+1.
  - The owner must tolerate one cycle of grant after dropping its request.
- Invariants:
  - grant always has zero or one bit set.
  - grant_idx always equals the binary encoding of grant.
  - A requester holding req high is granted within 7*MAX_HOLD + 1 cycles when MAX_HOLD!=0.
- Requests that rise and fall while another requester owns the grant are not remembered: no request latching.

Optional Feature:
- Macro: RR_ARBITER8_LOCK_EN.
- Defined:
  - Adds the lock input.
  - While grant_valid=1 and lock=1: hold_cnt freezes and limit release is suppressed.
  - Release on req[g]=0 still applies.
  - lock is ignored in IDLE.
- Undefined:
  - No lock port.
  - Behaviour exactly as above.

Test Plan:
- Reset, then req=8'b0000_0001 -> next cycle grant=8'b0000_0001, grant_idx=0, grant_valid=1.
- MAX_HOLD=4, req=8'hFF held -> grant_idx sequence 0,1,2,...,7,0. Each index held exactly 4 cycles; grant_valid never drops.
- pointer=0, req=8'b1000_0100 -> grant_idx=2. Drop req[2] -> next cycle grant_idx=7. Then req=8'b0000_0010 only, drop req[7] -> grant_idx=1 (wrap-around).
- MAX_HOLD=4, only req[4] held for 12 cycles -> grant=8'b0001_0000 continuously for all 12 cycles; grant_valid never drops.
- Grant owned by idx 5 for 2 cycles, assert rst for 1 cycle with req=8'hFF -> next cycle all outputs 0. After rst release, first grant goes to idx 0 (pointer reset).
- RR_ARBITER8_LOCK_EN defined, MAX_HOLD=4, req=8'h03, lock=1 for 10 cycles -> idx 0 held all 10 cycles. When lock=0, release follows the hold limit and the grant moves to idx 1.
